// File: rtl/mips_multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, funct
// codes, FSM states, ALU-decoder operation classes and datapath mux selects.
package mips_multicycle_controller_pkg;

  // Instruction opcodes, bits [31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function field, bits [5:0]
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // Controller states; codes 12..15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  // Operation class handed from the FSM to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  // ALU operation codes
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alucontrol_t;

  // ALU B operand selects
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Next-PC selects
  localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
  localparam logic [1:0] PCSRC_JUMP      = 2'b10;

endpackage

// File: rtl/mips_multicycle_controller_alu_decoder.sv
// ALU decoder: turns the FSM's operation class and the R-type funct field
// into the 3-bit ALU operation. Purely combinational.
module alu_decoder
  import mips_multicycle_controller_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // Fixed add/sub for address and branch math; funct decode for R-type
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      default: begin
        // aluop 10 and 11 both mean "look at funct"
        case (funct)
          FUNCT_ADD: alucontrol = ALU_ADD;
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control unit: Moore FSM that walks each instruction through
// fetch, decode and its class-specific execute/writeback states, driving the
// datapath enables and mux selects. ALU operation comes from alu_decoder.
module mips_multicycle_controller
  import mips_multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol
);

  state_t state;
  state_t next_state;
  aluop_t aluop;
  logic   pcwrite;
  logic   branch;

  // State register; reset is synchronous so it only takes effect on an edge
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // Next-state logic; op is only consulted in DECODE and MEMADR
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH: next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_RTYPEEX;
          OP_BEQ:       next_state = S_BEQEX;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JEX;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR:  next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   next_state = S_MEMWB;
      S_MEMWB:   next_state = S_FETCH;
      S_MEMWR:   next_state = S_FETCH;
      S_RTYPEEX: next_state = S_RTYPEWB;
      S_RTYPEWB: next_state = S_FETCH;
      S_BEQEX:   next_state = S_FETCH;
      S_ADDIEX:  next_state = S_ADDIWB;
      S_ADDIWB:  next_state = S_FETCH;
      S_JEX:     next_state = S_FETCH;
      default:   next_state = S_FETCH;
    endcase
  end

  // Moore outputs: everything defaults low, each state raises only what it needs
  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    alusrcb  = SRCB_REG;
    pcsrc    = PCSRC_ALURESULT;
    aluop    = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        pcwrite = 1'b1;
        irwrite = 1'b1;
        alusrcb = SRCB_FOUR;
        pcsrc   = PCSRC_ALURESULT;
      end
      // Speculatively compute the branch target while decoding
      S_DECODE: alusrcb = SRCB_IMM_SH2;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        branch  = 1'b1;
        pcsrc   = PCSRC_ALUOUT;
        aluop   = ALUOP_SUB;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JEX: begin
        pcwrite = 1'b1;
        pcsrc   = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

  // Branch is taken only when the subtraction in BEQEX yields zero
  assign pcen = pcwrite | (branch & zero);

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Self-checking bench for mips_multicycle_controller. Each scoreboard entry
// carries the inputs for one cycle plus the control word expected in it.
module tb_mips_multicycle_controller;

  typedef struct packed {
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
  } ctrl_t;

  typedef struct {
    string      name;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    ctrl_t      exp;
  } item_t;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  ctrl_t obs;
  item_t sb[$];
  item_t it;
  int    tests_run    = 0;
  int    tests_failed = 0;

  mips_multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol)
  );

  assign obs = {pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
                alusrcb, pcsrc, alucontrol};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags order: pcen memwrite irwrite regwrite alusrca iord memtoreg regdst
  function automatic ctrl_t mk(input logic [7:0] flags, input logic [1:0] srcb,
                               input logic [1:0] psrc, input logic [2:0] aluc);
    return {flags, srcb, psrc, aluc};
  endfunction

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
  localparam logic [5:0] UNDEF = 6'b111111, F_SUB = 6'b100010;

  localparam ctrl_t E_FETCH   = mk(8'b1010_0000, 2'b01, 2'b00, 3'b010);
  localparam ctrl_t E_DECODE  = mk(8'b0000_0000, 2'b11, 2'b00, 3'b010);
  localparam ctrl_t E_MEMADR  = mk(8'b0000_1000, 2'b10, 2'b00, 3'b010);
  localparam ctrl_t E_MEMRD   = mk(8'b0000_0100, 2'b00, 2'b00, 3'b010);
  localparam ctrl_t E_MEMWB   = mk(8'b0001_0010, 2'b00, 2'b00, 3'b010);
  localparam ctrl_t E_MEMWR   = mk(8'b0100_0100, 2'b00, 2'b00, 3'b010);
  localparam ctrl_t E_RTYPEWB = mk(8'b0001_0001, 2'b00, 2'b00, 3'b010);
  localparam ctrl_t E_ADDIEX  = mk(8'b0000_1000, 2'b10, 2'b00, 3'b010);
  localparam ctrl_t E_ADDIWB  = mk(8'b0001_0000, 2'b00, 2'b00, 3'b010);
  localparam ctrl_t E_JEX     = mk(8'b1000_0000, 2'b00, 2'b10, 3'b010);

  function automatic ctrl_t e_rtypeex(input logic [2:0] aluc);
    return mk(8'b0000_1000, 2'b00, 2'b00, aluc);
  endfunction

  function automatic ctrl_t e_beqex(input logic z);
    return mk({z, 7'b000_1000}, 2'b00, 2'b01, 3'b110);
  endfunction

  // Record one cycle of stimulus together with its expected controls
  task automatic push(input string name, input logic rst, input logic [5:0] o,
                      input logic [5:0] f, input logic z, input ctrl_t e);
    item_t n;
    n.name = name; n.rst = rst; n.op = o; n.funct = f; n.zero = z; n.exp = e;
    sb.push_back(n);
  endtask

  // Pop the next entry, drive its inputs, and wait until outputs settle
  task automatic apply(output item_t cur);
    cur   = sb.pop_front();
    reset = cur.rst;
    op    = cur.op;
    funct = cur.funct;
    zero  = cur.zero;
    @(negedge clk);
  endtask

  task automatic test_reset();
    push("rst_hold1",   1'b1, LW, 6'd0, 1'b0, E_FETCH);
    push("rst_hold2",   1'b1, LW, 6'd0, 1'b0, E_FETCH);
    push("rst_fetch",   1'b0, LW, 6'd0, 1'b0, E_FETCH);
    push("rst_decode",  1'b0, LW, 6'd0, 1'b0, E_DECODE);
    push("rst_memadr",  1'b0, LW, 6'd0, 1'b0, E_MEMADR);
    push("rst_memrd",   1'b0, LW, 6'd0, 1'b0, E_MEMRD);
    push("rst_memwb",   1'b0, LW, 6'd0, 1'b0, E_MEMWB);
    while (sb.size() != 0) begin
      apply(it);
      tests_run++;
      if (obs !== it.exp) begin
        tests_failed++;
        $display("FAIL %s: got %b required %b", it.name, obs, it.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw();
    push("lw_fetch",  1'b0, LW, 6'd0, 1'b0, E_FETCH);
    push("lw_decode", 1'b0, LW, 6'd0, 1'b0, E_DECODE);
    push("lw_memadr", 1'b0, LW, 6'd0, 1'b0, E_MEMADR);
    push("lw_memrd",  1'b0, LW, 6'd0, 1'b0, E_MEMRD);
    push("lw_memwb",  1'b0, LW, 6'd0, 1'b0, E_MEMWB);
    while (sb.size() != 0) begin
      apply(it);
      tests_run++;
      if (obs !== it.exp) begin
        tests_failed++;
        $display("FAIL %s: got %b required %b", it.name, obs, it.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw();
    push("sw_fetch",  1'b0, SW, 6'd0, 1'b0, E_FETCH);
    push("sw_decode", 1'b0, SW, 6'd0, 1'b0, E_DECODE);
    push("sw_memadr", 1'b0, SW, 6'd0, 1'b0, E_MEMADR);
    push("sw_memwr",  1'b0, SW, 6'd0, 1'b0, E_MEMWR);
    while (sb.size() != 0) begin
      apply(it);
      tests_run++;
      if (obs !== it.exp) begin
        tests_failed++;
        $display("FAIL %s: got %b required %b", it.name, obs, it.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn  [6] = '{6'b100010, 6'b100000, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    logic [2:0] exp [6] = '{3'b110,    3'b010,    3'b000,    3'b001,    3'b111,    3'b000};
    for (int k = 0; k < 6; k++) begin
      push($sformatf("rt%0d_fetch", k),   1'b0, RT, fn[k], 1'b0, E_FETCH);
      push($sformatf("rt%0d_decode", k),  1'b0, RT, fn[k], 1'b0, E_DECODE);
      push($sformatf("rt%0d_ex", k),      1'b0, RT, fn[k], 1'b0, e_rtypeex(exp[k]));
      push($sformatf("rt%0d_wb", k),      1'b0, RT, fn[k], 1'b0, E_RTYPEWB);
    end
    while (sb.size() != 0) begin
      apply(it);
      tests_run++;
      if (obs !== it.exp) begin
        tests_failed++;
        $display("FAIL %s: got %b required %b", it.name, obs, it.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_addi();
    push("addi_fetch",  1'b0, ADDI, 6'd0, 1'b0, E_FETCH);
    push("addi_decode", 1'b0, ADDI, 6'd0, 1'b0, E_DECODE);
    push("addi_ex",     1'b0, ADDI, 6'd0, 1'b0, E_ADDIEX);
    push("addi_wb",     1'b0, ADDI, 6'd0, 1'b0, E_ADDIWB);
    while (sb.size() != 0) begin
      apply(it);
      tests_run++;
      if (obs !== it.exp) begin
        tests_failed++;
        $display("FAIL %s: got %b required %b", it.name, obs, it.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  // zero held high in FETCH/DECODE too: pcen there must not follow it
  task automatic test_beq();
    push("beq_t_fetch",  1'b0, BEQ, 6'd0, 1'b1, E_FETCH);
    push("beq_t_decode", 1'b0, BEQ, 6'd0, 1'b1, E_DECODE);
    push("beq_t_ex",     1'b0, BEQ, 6'd0, 1'b1, e_beqex(1'b1));
    push("beq_n_fetch",  1'b0, BEQ, 6'd0, 1'b0, E_FETCH);
    push("beq_n_decode", 1'b0, BEQ, 6'd0, 1'b0, E_DECODE);
    push("beq_n_ex",     1'b0, BEQ, 6'd0, 1'b0, e_beqex(1'b0));
    while (sb.size() != 0) begin
      apply(it);
      tests_run++;
      if (obs !== it.exp) begin
        tests_failed++;
        $display("FAIL %s: got %b required %b", it.name, obs, it.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_j();
    push("j_fetch",  1'b0, JMP, 6'd0, 1'b0, E_FETCH);
    push("j_decode", 1'b0, JMP, 6'd0, 1'b0, E_DECODE);
    push("j_ex",     1'b0, JMP, 6'd0, 1'b0, E_JEX);
    push("j_refetch", 1'b0, RT, F_SUB, 1'b0, E_FETCH);
    push("j_redecode", 1'b0, RT, F_SUB, 1'b0, E_DECODE);
    push("j_rtex",   1'b0, RT, F_SUB, 1'b0, e_rtypeex(3'b110));
    push("j_rtwb",   1'b0, RT, F_SUB, 1'b0, E_RTYPEWB);
    while (sb.size() != 0) begin
      apply(it);
      tests_run++;
      if (obs !== it.exp) begin
        tests_failed++;
        $display("FAIL %s: got %b required %b", it.name, obs, it.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  // Reset raised during RTYPEEX: that cycle still shows RTYPEEX, next is FETCH
  task automatic test_reset_mid();
    push("mid_fetch",  1'b0, RT, F_SUB, 1'b0, E_FETCH);
    push("mid_decode", 1'b0, RT, F_SUB, 1'b0, E_DECODE);
    push("mid_rtex",   1'b1, RT, F_SUB, 1'b0, e_rtypeex(3'b110));
    push("mid_abort",  1'b1, RT, F_SUB, 1'b0, E_FETCH);
    while (sb.size() != 0) begin
      apply(it);
      tests_run++;
      if (obs !== it.exp) begin
        tests_failed++;
        $display("FAIL %s: got %b required %b", it.name, obs, it.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_undefined();
    push("undef_fetch",  1'b0, UNDEF, 6'd0, 1'b0, E_FETCH);
    push("undef_decode", 1'b0, UNDEF, 6'd0, 1'b0, E_DECODE);
    push("undef_back",   1'b0, SW,    6'd0, 1'b0, E_FETCH);
    push("undef_next",   1'b0, SW,    6'd0, 1'b0, E_DECODE);
    push("undef_sw_adr", 1'b0, SW,    6'd0, 1'b0, E_MEMADR);
    push("undef_sw_wr",  1'b0, SW,    6'd0, 1'b0, E_MEMWR);
    while (sb.size() != 0) begin
      apply(it);
      tests_run++;
      if (obs !== it.exp) begin
        tests_failed++;
        $display("FAIL %s: got %b required %b", it.name, obs, it.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    push("b2b_j_fetch",   1'b0, JMP, 6'd0, 1'b1, E_FETCH);
    push("b2b_j_decode",  1'b0, JMP, 6'd0, 1'b1, E_DECODE);
    push("b2b_j_ex",      1'b0, JMP, 6'd0, 1'b1, E_JEX);
    push("b2b_beq_fetch", 1'b0, BEQ, 6'd0, 1'b1, E_FETCH);
    push("b2b_beq_dec",   1'b0, BEQ, 6'd0, 1'b1, E_DECODE);
    push("b2b_beq_ex",    1'b0, BEQ, 6'd0, 1'b1, e_beqex(1'b1));
    push("b2b_addi_fetch", 1'b0, ADDI, 6'd0, 1'b0, E_FETCH);
    push("b2b_addi_dec",  1'b0, ADDI, 6'd0, 1'b0, E_DECODE);
    push("b2b_addi_ex",   1'b0, ADDI, 6'd0, 1'b0, E_ADDIEX);
    push("b2b_addi_wb",   1'b0, ADDI, 6'd0, 1'b0, E_ADDIWB);
    push("b2b_final",     1'b0, LW,  6'd0, 1'b0, E_FETCH);
    while (sb.size() != 0) begin
      apply(it);
      tests_run++;
      if (obs !== it.exp) begin
        tests_failed++;
        $display("FAIL %s: got %b required %b", it.name, obs, it.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  // Safety net in case the stimulus ever stops advancing
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    reset = 1'b1;
    op    = LW;
    funct = 6'd0;
    zero  = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_addi();
    test_beq();
    test_j();
    test_reset_mid();
    test_undefined();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
